// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter: FSM state encoding,
// owner encoding, default widths and the watchdog counter width helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;

  // Watchdog counter is at least 8 bits wide and always wide enough to hold the limit.
  function automatic int tmo_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w > 8) ? w : 8;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises IFU fetches and LSU data accesses onto one memory
// port with fixed LSU priority and routes each response back to its master.
// Optional downstream watchdog: define MEM_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | grant decision; capture owner request into mem_* registers
// REQ   | mem_reqValid high for exactly one cycle
// WAIT  | wait for mem_respValid (or watchdog expiry when enabled)
// RESP  | owner respValid high for exactly one cycle
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_reqValid,
  input  logic [ADDR_W-1:0]   ifu_raddr,
  output logic                ifu_respValid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_reqValid,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_respValid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_reqValid,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_respValid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                resp_err
);

  state_t              state;
  logic                owner;
  logic                wait_done;
  logic [DATA_W-1:0]   wait_data;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO_W = tmo_width(TIMEOUT);
  logic [TMO_W-1:0]    timer;
  logic                timed_out;
  logic                err_q;

  assign resp_err = err_q;
`else
  // Without the watchdog a response can never be an error (TIMEOUT is a non-negative count).
  assign resp_err = (TIMEOUT < 0);
`endif

  // WAIT completion: a real downstream response, or watchdog expiry on the WAIT
  // cycle that would bring the counter to TIMEOUT.
  always_comb begin
    wait_done = mem_respValid;
    wait_data = mem_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
    timed_out = !mem_respValid && (timer == TMO_W'(TIMEOUT - 1));
    if (timed_out) begin
      wait_done = 1'b1;
      wait_data = '0;
    end
`endif
  end

  // Arbitration FSM with registered downstream request and per-master response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      owner         <= OWN_IFU;
      mem_reqValid  <= 1'b0;
      mem_addr      <= '0;
      mem_wen       <= 1'b0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
      ifu_respValid <= 1'b0;
      ifu_rdata     <= '0;
      lsu_respValid <= 1'b0;
      lsu_rdata     <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      timer         <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (lsu_reqValid) begin
            owner        <= OWN_LSU;
            mem_addr     <= lsu_addr;
            mem_wen      <= lsu_wen;
            mem_wdata    <= lsu_wdata;
            mem_wmask    <= lsu_wmask;
            mem_reqValid <= 1'b1;
            state        <= REQ;
          end else if (ifu_reqValid) begin
            owner        <= OWN_IFU;
            mem_addr     <= ifu_raddr;
            mem_wen      <= 1'b0;
            mem_wdata    <= '0;
            mem_wmask    <= '0;
            mem_reqValid <= 1'b1;
            state        <= REQ;
          end
        end
        REQ: begin
          // A response pulse in this cycle is deliberately ignored.
          mem_reqValid <= 1'b0;
          state        <= WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
          timer        <= '0;
`endif
        end
        WAIT: begin
          if (wait_done) begin
            if (owner == OWN_LSU) begin
              lsu_respValid <= 1'b1;
              lsu_rdata     <= wait_data;
            end else begin
              ifu_respValid <= 1'b1;
              ifu_rdata     <= wait_data;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            err_q <= timed_out;
`endif
            state <= RESP;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else begin
            timer <= timer + 1'b1;
          end
`endif
        end
        RESP: begin
          ifu_respValid <= 1'b0;
          ifu_rdata     <= '0;
          lsu_respValid <= 1'b0;
          lsu_rdata     <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
          err_q         <= 1'b0;
`endif
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors with hand-computed expectations for the
// two-master memory arbiter. Downstream memory behaviour is driven inline.
module tb_mem_arbiter;

  localparam int TB_TMO = 4;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int SLOW_L = 3;
`else
  localparam int SLOW_L = 10;
`endif

  logic        clk;
  logic        rst;
  logic        ifu_reqValid;
  logic [31:0] ifu_raddr;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;
  logic        lsu_reqValid;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;
  logic        mem_reqValid;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_respValid;
  logic [31:0] mem_rdata;
  logic        resp_err;

  int n_chk;
  int n_err;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TB_TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_reqValid  (ifu_reqValid),
    .ifu_raddr     (ifu_raddr),
    .ifu_respValid (ifu_respValid),
    .ifu_rdata     (ifu_rdata),
    .lsu_reqValid  (lsu_reqValid),
    .lsu_addr      (lsu_addr),
    .lsu_wen       (lsu_wen),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_respValid (lsu_respValid),
    .lsu_rdata     (lsu_rdata),
    .mem_reqValid  (mem_reqValid),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_respValid (mem_respValid),
    .mem_rdata     (mem_rdata),
    .resp_err      (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; drive and sample there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_reqValid"},  mem_reqValid,  0);
    check({tag, "_mem_addr"},      mem_addr,      0);
    check({tag, "_mem_wen"},       mem_wen,       0);
    check({tag, "_mem_wdata"},     mem_wdata,     0);
    check({tag, "_mem_wmask"},     mem_wmask,     0);
    check({tag, "_ifu_respValid"}, ifu_respValid, 0);
    check({tag, "_ifu_rdata"},     ifu_rdata,     0);
    check({tag, "_lsu_respValid"}, lsu_respValid, 0);
    check({tag, "_lsu_rdata"},     lsu_rdata,     0);
    check({tag, "_resp_err"},      resp_err,      0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pulses;
    int resps;
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    ifu_reqValid = 0; ifu_raddr = 0;
    lsu_reqValid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    mem_respValid = 0; mem_rdata = 0;
    #2 rst = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b1;
    tick();

    // IFU-only read, downstream L=1
    ifu_reqValid = 1; ifu_raddr = 32'h8000_0000;
    tick();
    check("t1_req",     mem_reqValid, 1);
    check("t1_addr",    mem_addr, 32'h8000_0000);
    check("t1_wen",     mem_wen, 0);
    check("t1_wmask",   mem_wmask, 0);
    tick();
    check("t1_req_pulse", mem_reqValid, 0);
    check("t1_early_resp", ifu_respValid, 0);
    mem_respValid = 1; mem_rdata = 32'h0010_0073;
    tick();
    mem_respValid = 0; mem_rdata = 0;
    check("t1_resp",    ifu_respValid, 1);
    check("t1_rdata",   ifu_rdata, 32'h0010_0073);
    check("t1_lsu_q",   lsu_respValid, 0);
    check("t1_err",     resp_err, 0);
    ifu_reqValid = 0;
    tick();
    check("t1_resp_pulse", ifu_respValid, 0);
    check("t1_idle_req",   mem_reqValid, 0);

    // LSU write, downstream L=1
    lsu_reqValid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011;
    tick();
    check("t2_req",   mem_reqValid, 1);
    check("t2_addr",  mem_addr, 32'h8000_1000);
    check("t2_wen",   mem_wen, 1);
    check("t2_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("t2_wmask", mem_wmask, 4'b0011);
    tick();
    check("t2_req_pulse", mem_reqValid, 0);
    mem_respValid = 1; mem_rdata = 32'h1234_5678;
    tick();
    mem_respValid = 0; mem_rdata = 0;
    check("t2_resp",  lsu_respValid, 1);
    check("t2_rdata", lsu_rdata, 32'h1234_5678);
    check("t2_ifu_q", ifu_respValid, 0);
    lsu_reqValid = 0; lsu_wen = 0;
    tick();
    check("t2_resp_pulse", lsu_respValid, 0);

    // Simultaneous requests: LSU first, IFU two cycles after lsu_respValid
    ifu_reqValid = 1; ifu_raddr = 32'h8000_0004;
    lsu_reqValid = 1; lsu_addr = 32'h8000_2000; lsu_wen = 0;
    lsu_wdata = 32'h5555_AAAA; lsu_wmask = 4'hF;
    tick();
    check("t3_lsu_req",  mem_reqValid, 1);
    check("t3_lsu_addr", mem_addr, 32'h8000_2000);
    check("t3_lsu_wen",  mem_wen, 0);
    tick();
    mem_respValid = 1; mem_rdata = 32'hA1A1_A1A1;
    tick();
    mem_respValid = 0;
    check("t3_lsu_resp",  lsu_respValid, 1);
    check("t3_lsu_rdata", lsu_rdata, 32'hA1A1_A1A1);
    check("t3_ifu_quiet", ifu_respValid, 0);
    lsu_reqValid = 0;
    tick();
    check("t3_gap",       mem_reqValid, 0);
    check("t3_lsu_once",  lsu_respValid, 0);
    tick();
    check("t3_ifu_req",   mem_reqValid, 1);
    check("t3_ifu_addr",  mem_addr, 32'h8000_0004);
    check("t3_ifu_wmask", mem_wmask, 0);
    check("t3_ifu_wdata", mem_wdata, 0);
    tick();
    mem_respValid = 1; mem_rdata = 32'hB2B2_B2B2;
    tick();
    mem_respValid = 0;
    check("t3_ifu_resp",  ifu_respValid, 1);
    check("t3_ifu_rdata", ifu_rdata, 32'hB2B2_B2B2);
    check("t3_lsu_quiet", lsu_respValid, 0);
    ifu_reqValid = 0;
    tick();
    check("t3_ifu_once",  ifu_respValid, 0);
    check("t3_lsu_done",  lsu_respValid, 0);

    // Slow downstream; a response pulse in the REQ cycle must be ignored
    ifu_reqValid = 1; ifu_raddr = 32'h8000_0100;
    tick();
    check("t4_req", mem_reqValid, 1);
    mem_respValid = 1; mem_rdata = 32'hBAD0_BAD0;
    pulses = 0;
    resps = 0;
    for (int c = 2; c <= 1 + SLOW_L; c++) begin
      tick();
      mem_respValid = 0;
      if (c == 1 + SLOW_L) begin
        mem_respValid = 1; mem_rdata = 32'hCAFE_F00D;
      end
      pulses += int'(mem_reqValid);
      resps  += int'(ifu_respValid) + int'(lsu_respValid);
    end
    check("t4_single_req", pulses, 0);
    check("t4_no_early",   resps, 0);
    tick();
    mem_respValid = 0;
    check("t4_resp",  ifu_respValid, 1);
    check("t4_rdata", ifu_rdata, 32'hCAFE_F00D);
    ifu_reqValid = 0;
    tick();
    check("t4_resp_pulse", ifu_respValid, 0);

    // Reset asserted during WAIT drops the transaction
    ifu_reqValid = 1; ifu_raddr = 32'h8000_0040;
    tick();
    tick();
    #1 rst = 1'b0;
    ifu_reqValid = 0;
    #1;
    check_all_zero("t5_rst");
    rst = 1'b1;
    resps = 0;
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      resps  += int'(ifu_respValid) + int'(lsu_respValid);
      pulses += int'(mem_reqValid);
    end
    check("t5_no_resp", resps, 0);
    check("t5_no_req",  pulses, 0);
    ifu_reqValid = 1; ifu_raddr = 32'h8000_0080;
    tick();
    check("t5_req",  mem_reqValid, 1);
    check("t5_addr", mem_addr, 32'h8000_0080);
    tick();
    mem_respValid = 1; mem_rdata = 32'h0000_0013;
    tick();
    mem_respValid = 0;
    check("t5_resp",  ifu_respValid, 1);
    check("t5_rdata", ifu_rdata, 32'h0000_0013);
    ifu_reqValid = 0;
    tick();

`ifdef MEM_ARB_TIMEOUT_EN
    // Silent downstream: error response after TB_TMO WAIT cycles, late response ignored
    ifu_reqValid = 1; ifu_raddr = 32'h8000_0200;
    resps = 0;
    for (int c = 1; c <= 1 + TB_TMO; c++) begin
      tick();
      resps += int'(ifu_respValid);
    end
    check("t6_no_early", resps, 0);
    tick();
    check("t6_resp",  ifu_respValid, 1);
    check("t6_err",   resp_err, 1);
    check("t6_rdata", ifu_rdata, 0);
    ifu_reqValid = 0;
    tick();
    check("t6_resp_pulse", ifu_respValid, 0);
    check("t6_err_clear",  resp_err, 0);
    mem_respValid = 1; mem_rdata = 32'hDEAD_DEAD;
    tick();
    mem_respValid = 0;
    resps = 0;
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      resps  += int'(ifu_respValid) + int'(lsu_respValid) + int'(resp_err);
      pulses += int'(mem_reqValid);
      tick();
    end
    check("t6_late_ignored", resps, 0);
    check("t6_late_no_req",  pulses, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
